// File: rtl/arbeiter_rr4.sv
// -----------------------------------------------------------------------------
// arbeiter_rr4 -- four-way round-robin arbiter with bounded tenure
//
// Grants one of four level-sensitive requesters at a time. A 2-bit priority
// pointer selects the winner: the first pending request found scanning
// pointer, pointer+1, ... modulo 4. Every new grant moves the pointer to just
// past the new owner, so the owner becomes lowest priority for the next pick.
//
// An owner keeps the grant while its request stays high, but a tenure counter
// limits it to MAX_TENURE consecutive cycles whenever another requester is
// waiting. Without contention the counter simply reloads and the owner
// continues. All outputs are registered; a handover between two requesters
// happens in a single edge with no idle cycle in between.
//
// Parameters
//   MAX_TENURE  maximum consecutive grant cycles under contention (1..255)
//
// Ports
//   clock              in   sole clock, rising-edge
//   reset              in   asynchronous, active-low reset
//   req_0 .. req_3     in   request from requester n, held high while wanted
//   gnt_0 .. gnt_3     out  registered grant, one-hot or all-zero
//   gnt_id     [1:0]   out  registered index of the owner, valid while busy
//   busy               out  registered, high while any grant is high
// -----------------------------------------------------------------------------
module arbeiter_rr4 #(
   parameter int unsigned MAX_TENURE = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_0,
   input  logic       req_1,
   input  logic       req_2,
   input  logic       req_3,
   output logic       gnt_0,
   output logic       gnt_1,
   output logic       gnt_2,
   output logic       gnt_3,
   output logic [1:0] gnt_id,
   output logic       busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Result of a round-robin scan: whether anyone was found, and who.
   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   localparam logic [7:0] TENURE_MAX = 8'(MAX_TENURE);

   // Return the first set bit of req starting at position ptr, wrapping at 4.
   function automatic pick_t pick_first(input logic [3:0] req,
                                        input logic [1:0] ptr);
      pick_t      res;
      logic [1:0] idx;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!res.found && req[idx]) begin
            res.found = 1'b1;
            res.idx   = idx;
         end
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t     state_q,  state_d;
   logic [1:0] ptr_q,    ptr_d;
   logic [7:0] cnt_q,    cnt_d;
   logic [3:0] gnt_q,    gnt_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic       busy_q,   busy_d;

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   logic [3:0] req_vec;
   logic [3:0] owner_mask;
   logic [3:0] others_vec;
   logic       owner_req;
   logic       at_limit;
   pick_t      pick_any;
   pick_t      pick_other;

   assign req_vec    = {req_3, req_2, req_1, req_0};
   assign owner_mask = 4'b0001 << gnt_id_q;
   assign owner_req  = |(req_vec & owner_mask);
   // The owner is excluded when looking for a successor, so a handover can
   // never re-select the requester that is being moved off the grant.
   assign others_vec = req_vec & ~owner_mask;
   assign at_limit   = (cnt_q >= TENURE_MAX);
   assign pick_any   = pick_first(req_vec, ptr_q);
   assign pick_other = pick_first(others_vec, ptr_q);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   logic       new_grant;
   logic [1:0] new_id;

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      new_grant = 1'b0;
      new_id    = 2'd0;

      unique case (state_q)
         IDLE: begin
            if (pick_any.found) begin
               new_grant = 1'b1;
               new_id    = pick_any.idx;
            end
         end

         GRANT: begin
            if (!owner_req) begin
               // Owner released: hand straight over, or fall back to idle.
               if (pick_other.found) begin
                  new_grant = 1'b1;
                  new_id    = pick_other.idx;
               end else begin
                  state_d  = IDLE;
                  gnt_d    = 4'b0000;
                  gnt_id_d = 2'd0;
               end
            end else if (at_limit) begin
               // Tenure used up: yield if anyone waits, else start a new term.
               if (pick_other.found) begin
                  new_grant = 1'b1;
                  new_id    = pick_other.idx;
               end else begin
                  cnt_d = 8'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d  = IDLE;
            gnt_d    = 4'b0000;
            gnt_id_d = 2'd0;
         end
      endcase

      if (new_grant) begin
         state_d  = GRANT;
         gnt_d    = 4'b0001 << new_id;
         gnt_id_d = new_id;
         ptr_d    = new_id + 2'd1;
         cnt_d    = 8'd1;
      end

      busy_d = |gnt_d;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         ptr_q    <= 2'd0;
         cnt_q    <= 8'd0;
         gnt_q    <= 4'b0000;
         gnt_id_q <= 2'd0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign gnt_0  = gnt_q[0];
   assign gnt_1  = gnt_q[1];
   assign gnt_2  = gnt_q[2];
   assign gnt_3  = gnt_q[3];
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_arbeiter_rr4.sv
// -----------------------------------------------------------------------------
// tb_arbeiter_rr4 -- directed self-checking bench for arbeiter_rr4
//
// Two instances: dut with the default tenure of 8, dut1 with tenure 1.
// Inputs change on the falling clock edge; outputs are sampled on the falling
// edge that follows each rising edge.
// -----------------------------------------------------------------------------
module tb_arbeiter_rr4;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_0, req_1, req_2, req_3;
   logic       gnt_0, gnt_1, gnt_2, gnt_3;
   logic [1:0] gnt_id;
   logic       busy;

   logic       r1_0, r1_1, r1_2, r1_3;
   logic       g1_0, g1_1, g1_2, g1_3;
   logic [1:0] id1;
   logic       busy1;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   arbeiter_rr4 #(.MAX_TENURE(8)) dut (
      .clock (clock),
      .reset (reset),
      .req_0 (req_0),
      .req_1 (req_1),
      .req_2 (req_2),
      .req_3 (req_3),
      .gnt_0 (gnt_0),
      .gnt_1 (gnt_1),
      .gnt_2 (gnt_2),
      .gnt_3 (gnt_3),
      .gnt_id(gnt_id),
      .busy  (busy)
   );

   arbeiter_rr4 #(.MAX_TENURE(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .req_0 (r1_0),
      .req_1 (r1_1),
      .req_2 (r1_2),
      .req_3 (r1_3),
      .gnt_0 (g1_0),
      .gnt_1 (g1_1),
      .gnt_2 (g1_2),
      .gnt_3 (g1_3),
      .gnt_id(id1),
      .busy  (busy1)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Grant vector, busy, and (while busy) the owner index of dut.
   task automatic expect_state(input string tag, input logic [3:0] exp_gnt,
                               input logic [1:0] exp_id, input logic exp_busy);
      check({tag, "/gnt"}, 32'({gnt_3, gnt_2, gnt_1, gnt_0}), 32'(exp_gnt));
      check({tag, "/busy"}, 32'(busy), 32'(exp_busy));
      if (exp_busy) check({tag, "/id"}, 32'(gnt_id), 32'(exp_id));
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      {req_3, req_2, req_1, req_0} = 4'b0000;
      {r1_3, r1_2, r1_1, r1_0}     = 4'b0000;

      // Reset state
      tick();
      expect_state("reset", 4'b0000, 2'd0, 1'b0);
      check("reset/id", 32'(gnt_id), 32'd0);
      reset = 1'b1;

      // Idle for 10 cycles with no requests
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_state($sformatf("idle%0d", i), 4'b0000, 2'd0, 1'b0);
         check($sformatf("idle%0d/id", i), 32'(gnt_id), 32'd0);
      end

      // A request pulse that is gone before the rising edge is ignored
      req_0 = 1'b1;
      #3;
      req_0 = 1'b0;
      tick();
      expect_state("glitch", 4'b0000, 2'd0, 1'b0);

      // req_2 alone: grant after one edge, release after it drops
      req_2 = 1'b1;
      tick();
      expect_state("r2_k", 4'b0100, 2'd2, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         expect_state($sformatf("r2_k%0d", i), 4'b0100, 2'd2, 1'b1);
      end
      req_2 = 1'b0;
      tick();
      expect_state("r2_drop", 4'b0000, 2'd0, 1'b0);

      // All four requesting from pointer 0: 8 cycles each in order 0,1,2,3,0
      reset = 1'b0;
      tick();
      reset = 1'b1;
      {req_3, req_2, req_1, req_0} = 4'b1111;
      for (int i = 0; i < 40; i++) begin
         tick();
         expect_state($sformatf("all%0d", i), 4'b0001 << ((i / 8) % 4),
                      2'((i / 8) % 4), 1'b1);
      end
      {req_3, req_2, req_1, req_0} = 4'b0000;
      tick();
      expect_state("all_drop", 4'b0000, 2'd0, 1'b0);

      // req_1 alone for 20 cycles keeps the grant across counter reloads
      reset = 1'b0;
      tick();
      reset = 1'b1;
      req_1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         expect_state($sformatf("solo%0d", i), 4'b0010, 2'd1, 1'b1);
      end
      // Last reload was at the 17th edge; four more cycles of tenure remain
      req_3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_state($sformatf("cont%0d", i), 4'b0010, 2'd1, 1'b1);
      end
      tick();
      expect_state("preempt", 4'b1000, 2'd3, 1'b1);
      // Owner 3 releases while req_1 waits: immediate handover
      req_3 = 1'b0;
      tick();
      expect_state("handback", 4'b0010, 2'd1, 1'b1);
      req_1 = 1'b0;
      tick();
      expect_state("solo_drop", 4'b0000, 2'd0, 1'b0);

      // Tenure 1: two requesters alternate every cycle, starting with 0
      r1_0 = 1'b1;
      r1_3 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("t1_%0d/gnt", i), 32'({g1_3, g1_2, g1_1, g1_0}),
               (i % 2 == 0) ? 32'h1 : 32'h8);
         check($sformatf("t1_%0d/id", i), 32'(id1),
               (i % 2 == 0) ? 32'd0 : 32'd3);
         check($sformatf("t1_%0d/busy", i), 32'(busy1), 32'd1);
      end
      r1_0 = 1'b0;
      r1_3 = 1'b0;
      tick();
      check("t1_drop/busy", 32'(busy1), 32'd0);

      // Asynchronous reset mid-grant (pointer is 2 after the last grant to 1)
      req_2 = 1'b1;
      tick();
      expect_state("pre_rst", 4'b0100, 2'd2, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      expect_state("async_rst", 4'b0000, 2'd0, 1'b0);
      check("async_rst/id", 32'(gnt_id), 32'd0);
      req_1 = 1'b1;
      tick();
      expect_state("rst_hold", 4'b0000, 2'd0, 1'b0);
      reset = 1'b1;
      tick();
      expect_state("post_rst", 4'b0010, 2'd1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/arbeiter_rr4.md
ARBEITER_RR4 -- requirements
Module: arbeiter_rr4

Interface
REQ-001 The block SHALL have parameter MAX_TENURE, default 8, meaning the maximum consecutive grant cycles for one owner while another requester waits; legal range 1..255.
REQ-002 The block SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have ports req_0, req_1, req_2, req_3  input  1 each  request from requester n, level-sensitive, held high while access is wanted.
REQ-005 The block SHALL have ports gnt_0, gnt_1, gnt_2, gnt_3  output  1 each  grant to requester n, registered.
REQ-006 The block SHALL have port gnt_id  output  2  index of the current owner, registered; valid only while busy=1.
REQ-007 The block SHALL have port busy  output  1  high while any gnt_n is high, registered.

Function
REQ-008 The block SHALL implement two states: IDLE (no grant) and GRANT (exactly one gnt_n high).
REQ-009 gnt_0..gnt_3 SHALL be one-hot or all-zero on every cycle; busy SHALL equal the OR of gnt_0..gnt_3.
REQ-010 The block SHALL keep a 2-bit priority pointer; the selected requester is the first pending req_n scanning pointer, pointer+1, ... modulo 4.
REQ-011 In IDLE, if any req_n is high at a rising edge, the block SHALL enter GRANT at that edge with the selected requester's gnt_n high (one-cycle latency, request to grant).
REQ-012 On every new grant to requester n the pointer SHALL become (n+1) mod 4 and the 8-bit tenure counter SHALL load 1.
REQ-013 In GRANT, while the owner's req is high, the counter SHALL increment each edge, saturating at MAX_TENURE.
REQ-014 In GRANT, if the owner's req is low at an edge, the grant SHALL move at that edge to the selected other pending requester, or to IDLE with all grants low if none pending; no dead cycle on handover.
REQ-015 In GRANT, if counter equals MAX_TENURE and any other req is high at an edge, the grant SHALL move at that edge to the selected other requester, even though the owner still requests.
REQ-016 If counter equals MAX_TENURE and no other req is high, the owner SHALL keep the grant and the counter SHALL reload 1.
REQ-017 An owner holding the grant continuously SHALL therefore have gnt_n high for at most MAX_TENURE consecutive cycles while contention exists.
REQ-018 With MAX_TENURE=1, the block SHALL rotate the grant every cycle among all pending requesters.
REQ-019 When the grant is handed over, gnt_id SHALL update at the same edge as gnt_n.
REQ-020 Requests changing between edges SHALL have no effect; only values at rising edges are used.

Reset
REQ-021 While reset=0, the block SHALL asynchronously force gnt_0..gnt_3=0, gnt_id=0, busy=0, pointer=0, counter=0, state IDLE, regardless of clock.
REQ-022 Reset asserted mid-grant SHALL drop the grant immediately without waiting for a clock edge.
REQ-023 After reset deasserts, the first rising edge with any req high SHALL grant per REQ-011 with pointer 0 (req_0 highest priority).

Verification (clock period 10, MAX_TENURE=8 unless stated)
REQ-024 Reset then req_0..3=0 for 10 cycles -> all gnt 0, busy 0, gnt_id 0 throughout.
REQ-025 After reset, req_2=1 alone at edge k -> gnt_2=1, gnt_id=2, busy=1 after edge k; req_2 dropped before edge k+5 -> all grants 0 after edge k+5.
REQ-026 After reset, req_0..3 all held high -> grants gnt_0, gnt_1, gnt_2, gnt_3, gnt_0 in order, each high exactly 8 consecutive cycles, never two high at once.
REQ-027 req_1 alone held 20 cycles -> gnt_1 stays high all 20 cycles (counter reloads, no release); req_3 raised at cycle 20 -> gnt_3 within 8 cycles of the last counter reload.
REQ-028 MAX_TENURE=1, req_0 and req_3 held -> gnt_0, gnt_3, gnt_0, gnt_3 alternating every cycle.
REQ-029 reset driven to 0 mid-cycle while gnt_2=1 -> gnt_2=0, busy=0 before next clock edge; after release with req_1 and req_2 high, gnt_1 wins (pointer 0).
